// File: rtl/ps2_move_arbiter.sv
// PS/2 arrow-key decoder with last-pressed-wins arbitration and rate-limited
// movement step pulses for the winning direction.
module ps2_move_arbiter #(
    parameter int STEP_CYCLES   = 833333,
    parameter int CNT_W         = 20,
    parameter bit ACCEPT_NUMPAD = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       enable,
    output logic [3:0] dir,
    output logic       step,
    output logic [3:0] held
);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_RESET = 8'hAA;
    localparam logic [3:0] DIR_STOP   = 4'd5;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t           state_q, state_n;
    logic [1:0]       list_q [4];
    logic [1:0]       list_n [4];
    logic [2:0]       count_q, count_n;
    logic [3:0]       held_q, held_n;
    logic [3:0]       dir_q, dir_n;
    logic             step_q, step_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic             is_arrow;
    logic [1:0]       key;
    logic             do_make, do_break, shifted;

    // Key id doubles as (dir code - 1): left, right, down, up.
    always_comb begin
        is_arrow = 1'b1;
        key      = 2'd0;
        case (rx_data)
            8'h6B:   key = 2'd0;
            8'h74:   key = 2'd1;
            8'h72:   key = 2'd2;
            8'h75:   key = 2'd3;
            default: is_arrow = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state_q;
        list_n   = list_q;
        count_n  = count_q;
        held_n   = held_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        shifted  = 1'b0;

        if (rx_done_tick) begin
            if (rx_data == CODE_RESET) begin
                state_n = IDLE;
                count_n = 3'd0;
                held_n  = 4'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rx_data == CODE_EXT)
                            state_n = EXT;
                        else if (rx_data == CODE_BRK)
                            state_n = BRK;
                        else if (is_arrow && ACCEPT_NUMPAD)
                            do_make = 1'b1;
                    end
                    EXT: begin
                        if (rx_data == CODE_BRK) begin
                            state_n = EXT_BRK;
                        end else if (rx_data != CODE_EXT) begin
                            do_make = is_arrow;
                            state_n = IDLE;
                        end
                    end
                    BRK: begin
                        do_break = is_arrow && ACCEPT_NUMPAD;
                        state_n  = IDLE;
                    end
                    default: begin
                        do_break = is_arrow;
                        state_n  = IDLE;
                    end
                endcase
            end
        end

        // Typematic repeats and breaks of unheld keys fall through untouched.
        if (do_make && !held_q[key]) begin
            list_n[0] = key;
            for (int i = 1; i < 4; i++)
                list_n[i] = list_q[i-1];
            count_n     = count_q + 3'd1;
            held_n[key] = 1'b1;
        end

        if (do_break && held_q[key]) begin
            for (int i = 0; i < 3; i++) begin
                if (list_q[i] == key && i < int'(count_q))
                    shifted = 1'b1;
                if (shifted)
                    list_n[i] = list_q[i+1];
            end
            count_n     = count_q - 3'd1;
            held_n[key] = 1'b0;
        end
    end

    // Any change to a new non-stop direction restarts the step phase.
    always_comb begin
        dir_n  = (enable && count_n != 3'd0) ? ({2'b00, list_n[0]} + 4'd1) : DIR_STOP;
        step_n = 1'b0;
        cnt_n  = '0;
        if (dir_n != DIR_STOP) begin
            if (dir_n != dir_q || cnt_q == '0) begin
                step_n = 1'b1;
                cnt_n  = RELOAD;
            end else begin
                cnt_n  = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < 4; i++)
                list_q[i] <= 2'd0;
            count_q <= 3'd0;
            held_q  <= 4'd0;
            dir_q   <= DIR_STOP;
            step_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            list_q  <= list_n;
            count_q <= count_n;
            held_q  <= held_n;
            dir_q   <= dir_n;
            step_q  <= step_n;
            cnt_q   <= cnt_n;
        end
    end

    assign dir  = dir_q;
    assign step = step_q;
    assign held = held_q;

endmodule

// File: tb/tb_ps2_move_arbiter.sv
// Drives two arbiters (numpad accepted / E0-only) with directed and random
// PS/2 byte streams and compares them against a queue-based key model.
module tb_ps2_move_arbiter;

    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       enable;
    logic [3:0] dir_a, dir_b, held_a, held_b;
    logic       step_a, step_b;

    int asserts = 0;
    int fails   = 0;

    int keyq [2][$];
    bit m_ext [2];
    bit m_brk [2];
    int e_dir [2];
    int e_step [2];
    int e_held [2];
    int since [2];

    ps2_move_arbiter #(.STEP_CYCLES(STEP), .CNT_W(3), .ACCEPT_NUMPAD(1'b1)) dut_a (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .enable(enable), .dir(dir_a), .step(step_a), .held(held_a)
    );

    ps2_move_arbiter #(.STEP_CYCLES(STEP), .CNT_W(3), .ACCEPT_NUMPAD(1'b0)) dut_b (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .enable(enable), .dir(dir_b), .step(step_b), .held(held_b)
    );

    always #5 clk = ~clk;

    function automatic int arrow_id(input logic [7:0] b);
        case (b)
            8'h6B:   return 0;
            8'h74:   return 1;
            8'h72:   return 2;
            8'h75:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_press(input int m, input int id);
        bit found = 0;
        foreach (keyq[m][i]) if (keyq[m][i] == id) found = 1;
        if (!found) keyq[m].push_front(id);
    endtask

    task automatic model_release(input int m, input int id);
        int pos = -1;
        foreach (keyq[m][i]) if (keyq[m][i] == id) pos = i;
        if (pos >= 0) keyq[m].delete(pos);
    endtask

    // Byte interpretation from the prefix rules; instance 0 also accepts bare arrows.
    task automatic model_byte(input int m, input logic [7:0] b);
        int id = arrow_id(b);
        bit numpad = (m == 0);
        if (b == 8'hAA) begin
            keyq[m].delete();
            m_ext[m] = 0;
            m_brk[m] = 0;
        end else if (!m_ext[m] && !m_brk[m]) begin
            if (b == 8'hE0) m_ext[m] = 1;
            else if (b == 8'hF0) m_brk[m] = 1;
            else if (id >= 0 && numpad) model_press(m, id);
        end else if (m_ext[m] && !m_brk[m]) begin
            if (b == 8'hF0) m_brk[m] = 1;
            else if (b != 8'hE0) begin
                if (id >= 0) model_press(m, id);
                m_ext[m] = 0;
            end
        end else begin
            if (id >= 0 && (m_ext[m] || numpad)) model_release(m, id);
            m_ext[m] = 0;
            m_brk[m] = 0;
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            int nd;
            if (reset) begin
                keyq[m].delete();
                m_ext[m] = 0; m_brk[m] = 0;
                e_dir[m] = 5; e_step[m] = 0; e_held[m] = 0; since[m] = 0;
            end else begin
                if (rx_done_tick) model_byte(m, rx_data);
                nd = (enable && keyq[m].size() > 0) ? keyq[m][0] + 1 : 5;
                if (nd == 5) begin
                    e_step[m] = 0; since[m] = 0;
                end else if (nd != e_dir[m]) begin
                    e_step[m] = 1; since[m] = 0;
                end else begin
                    since[m]++;
                    e_step[m] = (since[m] == STEP) ? 1 : 0;
                    if (since[m] == STEP) since[m] = 0;
                end
                e_dir[m]  = nd;
                e_held[m] = 0;
                foreach (keyq[m][i]) e_held[m] |= (1 << keyq[m][i]);
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: inputs held across the rising edge, outputs checked on the falling edge.
    task automatic applyStimulus(input logic tk, input logic [7:0] b);
        rx_done_tick = tk;
        rx_data      = b;
        @(posedge clk);
        model_update();
        @(negedge clk);
        checkOutput("dir_a",  32'(dir_a),  32'(e_dir[0]));
        checkOutput("step_a", 32'(step_a), 32'(e_step[0]));
        checkOutput("held_a", 32'(held_a), 32'(e_held[0]));
        checkOutput("dir_b",  32'(dir_b),  32'(e_dir[1]));
        checkOutput("step_b", 32'(step_b), 32'(e_step[1]));
        checkOutput("held_b", 32'(held_b), 32'(e_held[1]));
        rx_done_tick = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        applyStimulus(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    initial begin
        int pulses;
        logic [7:0] b;
        logic tk;
        reset = 1'b1; enable = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00;
        idle(2);
        checkOutput("reset_dir",  32'(dir_a),  32'd5);
        checkOutput("reset_step", 32'(step_a), 32'd0);
        checkOutput("reset_held", 32'(held_a), 32'd0);
        reset = 1'b0;

        $display("[TB] single key and step period");
        send(8'hE0); send(8'h6B);
        checkOutput("left_dir",  32'(dir_a),  32'd1);
        checkOutput("left_step", 32'(step_a), 32'd1);
        checkOutput("left_held", 32'(held_a), 32'b0001);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            pulses += int'(step_a);
        end
        checkOutput("period_pulses", 32'(pulses), 32'd3);

        $display("[TB] last pressed wins");
        send(8'hE0); send(8'h75);
        checkOutput("up_dir",  32'(dir_a),  32'd4);
        checkOutput("up_step", 32'(step_a), 32'd1);
        checkOutput("up_held", 32'(held_a), 32'b1001);
        send(8'hE0); send(8'hF0); send(8'h75);
        checkOutput("fallback_dir",  32'(dir_a),  32'd1);
        checkOutput("fallback_step", 32'(step_a), 32'd1);
        checkOutput("fallback_held", 32'(held_a), 32'b0001);
        send(8'hE0); send(8'hF0); send(8'h6B);
        checkOutput("stop_dir",  32'(dir_a),  32'd5);
        checkOutput("stop_step", 32'(step_a), 32'd0);
        checkOutput("stop_held", 32'(held_a), 32'd0);

        $display("[TB] middle removal");
        send(8'hE0); send(8'h74); send(8'hE0); send(8'h72); send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h72);
        checkOutput("mid_dir",  32'(dir_a),  32'd4);
        checkOutput("mid_held", 32'(held_a), 32'b1010);
        send(8'hE0); send(8'hF0); send(8'h75);
        checkOutput("mid_fallback_dir", 32'(dir_a), 32'd2);
        send(8'hE0); send(8'hF0); send(8'h74);

        $display("[TB] numpad rejection and typematic repeat");
        send(8'h72);
        checkOutput("bare_dir_b",  32'(dir_b),  32'd5);
        checkOutput("bare_held_b", 32'(held_b), 32'd0);
        checkOutput("bare_dir_a",  32'(dir_a),  32'd3);
        send(8'hE0); send(8'h72);
        checkOutput("ext_dir_b", 32'(dir_b), 32'd3);
        idle(2);
        send(8'hE0); send(8'h72);
        checkOutput("repeat_dir_b",  32'(dir_b),  32'd3);
        checkOutput("repeat_held_b", 32'(held_b), 32'b0100);

        $display("[TB] self-test clear and mid-sequence reset");
        send(8'hE0); send(8'h75);
        send(8'hAA);
        checkOutput("aa_held", 32'(held_a), 32'd0);
        checkOutput("aa_dir",  32'(dir_a),  32'd5);
        send(8'hE0); send(8'hF0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        send(8'h75);
        checkOutput("post_reset_dir",   32'(dir_a), 32'd4);
        checkOutput("post_reset_dir_b", 32'(dir_b), 32'd5);
        send(8'hAA);

        $display("[TB] enable gating");
        enable = 1'b0;
        send(8'hE0); send(8'h6B);
        checkOutput("dis_dir",  32'(dir_a),  32'd5);
        checkOutput("dis_step", 32'(step_a), 32'd0);
        checkOutput("dis_held", 32'(held_a), 32'b0001);
        enable = 1'b1;
        idle(1);
        checkOutput("en_dir",  32'(dir_a),  32'd1);
        checkOutput("en_step", 32'(step_a), 32'd1);
        send(8'hAA);

        $display("[TB] random byte stream");
        for (int n = 0; n < 3000; n++) begin
            int r   = int'($urandom_range(0, 99));
            int idx = int'($urandom_range(0, 15));
            reset = (r < 1);
            if (r >= 97) enable = ~enable;
            case (idx)
                0, 1, 2:  b = 8'hE0;
                3, 4, 5:  b = 8'hF0;
                6, 7:     b = 8'h6B;
                8, 9:     b = 8'h74;
                10, 11:   b = 8'h72;
                12, 13:   b = 8'h75;
                14:       b = 8'hAA;
                default:  b = 8'($urandom);
            endcase
            tk = ($urandom_range(0, 2) == 0);
            applyStimulus(tk, b);
        end
        reset = 1'b0;
        enable = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/ps2_move_arbiter.md
Name: ps2_move_arbiter

Overview:
- Sits between the PS/2 receiver (raw byte + done tick) and the game's player-movement logic.
- Decodes make and break sequences for the four arrow keys, including the E0 extended prefix, and tracks which arrows are held.
- Arbitrates simultaneous held keys with a last-pressed-wins policy and falls back to earlier still-held keys on release.
- Schedules rate-limited movement step pulses for the winning direction.

Parameters:
- STEP_CYCLES, 833333: clock cycles between consecutive step pulses while a direction is held. Must be ≥ 2.
- CNT_W, 20: step counter width. Requires STEP_CYCLES ≤ 2^CNT_W.
- ACCEPT_NUMPAD, 1: when 1, arrow codes without the E0 prefix are also accepted. When 0, only E0-prefixed arrow codes are accepted.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_done_tick  in  1  one-cycle pulse: rx_data holds a valid received byte
- rx_data  in  8  byte from the PS/2 receiver
- enable  in  1  when 0: dir forced to stop and step suppressed; key tracking continues
- dir  out  4  1=left, 2=right, 3=down, 4=up, 5=stop (registered)
- step  out  1  one-cycle movement pulse (registered)
- held  out  4  bit0=left, bit1=right, bit2=down, bit3=up (registered)

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values:
  - dir=5, step=0, held=0.
  - Recency list empty, decoder in IDLE, step counter=0.
- Key codes: left 6B, right 74, down 72, up 75.
  - Prefixes: E0 (extended), F0 (break).
  - AA (keyboard self-test passed / hotplug) clears all keys.
- Decoder FSM. States are IDLE, EXT, BRK, EXT_BRK; it advances only on cycles where rx_done_tick=1.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - AA -> clear held and list, stay IDLE.
    - Arrow code -> make event only if ACCEPT_NUMPAD=1.
    - Any other byte is ignored.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay EXT.
    - Arrow code -> make event, then IDLE.
    - Any other byte -> IDLE.
  - BRK: arrow code -> break event only if ACCEPT_NUMPAD=1; any byte -> IDLE.
  - EXT_BRK: arrow code -> break event; any byte -> IDLE.
  - An AA byte received in any state clears all keys and returns the FSM to IDLE.
- Recency list: up to 4 entries, each a 2-bit key id, ordered newest first.
  - Make of a key not held: push it to the front and set its held bit.
  - Make of a key already held (typematic repeat): no change.
  - Break of a held key: remove it from any position, close the gap, clear its held bit.
  - Break of a key not held: ignored.
  - List can never overflow, because there are only 4 distinct keys.
- Arbitration: the winner is the front entry of the list. An empty list means stop.
- Outputs:
  - dir = enable ? winner code : 5.
  - held and dir update in the cycle after the rx_done_tick cycle (1-cycle latency).
- Step scheduler:
  - Whenever registered dir changes to a non-stop value, step=1 in the same cycle the new dir first appears, and the counter loads STEP_CYCLES-1.
    - This covers stop->direction, direction->another direction, and enable rising while a key is held.
  - Otherwise, while dir≠5: the counter decrements each cycle. At 0, step=1 and the counter reloads STEP_CYCLES-1. The result is a period of exactly STEP_CYCLES cycles.
  - When dir=5: counter held at 0, step=0.
  - A change from direction A to B restarts the phase. No step is generated for A in that cycle.
- Reset asserted mid-sequence (e.g., after E0 or F0) discards the partial sequence and returns all registers to their reset values in the next cycle.

Test Plan:
- Set STEP_CYCLES=4. Send E0,6B, then idle 12 cycles.
  - Required: dir=1 and step=1 one cycle after the 6B tick, then step every 4 cycles (3 pulses after the first); held=0001.
- Hold left (E0,6B), then send E0,75.
  - Required: dir=4 with an immediate step and held=1001.
  - Then send E0,F0,75. Required: dir=1 with an immediate step and held=0001.
  - Then send E0,F0,6B. Required: dir=5, step stays 0, held=0000.
- Press right, down, up in that order, then break down (the middle entry).
  - Required: dir stays 4 and no extra step.
  - Then break up. Required: dir=2.
- With ACCEPT_NUMPAD=0, send bare 72.
  - Required: dir=5, held=0000.
  - Then send E0,72. Required: dir=3.
  - Then send a repeated E0,72. Required: no reorder and no extra step beyond the periodic ones.
- Hold up, then send AA.
  - Required: held=0000, dir=5.
  - Separately, send E0,F0 then assert reset for 1 cycle, then send 75 with ACCEPT_NUMPAD=1. Required: treated as a make, dir=4.
- Hold left with enable=0.
  - Required: dir=5, step=0, held=0001.
  - Raise enable. Required: dir=1 and step=1 on the first enabled output cycle.
